// File: rtl/fan_ctrl_poll_master.sv
// Autonomous Avalon-MM poller for the fan PIO: read sensor, apply hysteresis, write fan on change.
// Latency: read starts 1 clk after wait expiry, write 4 clks after poll start; slave has no waitrequest, so no backpressure.
module fan_ctrl_poll_master #(
    parameter int unsigned POLL_CYCLES = 50000,
    parameter logic [31:0] TEMP_HI     = 32'd70,
    parameter logic [31:0] TEMP_LO     = 32'd60,
    parameter logic [31:0] FAN_ON_VAL  = 32'h00000001,
    parameter logic [31:0] FAN_OFF_VAL = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_now,
    input  logic        force_on,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        fan_state,
    output logic        sensor_fault,
    output logic        busy,
    output logic [15:0] write_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RD_ADDR, S_RD_CAP, S_EVAL, S_WR
    } state_t;

    localparam logic [23:0] RELOAD = 24'(POLL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [31:0] temp_q, temp_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fan_q, fan_d;
    logic        fault_q, fault_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            temp_q  <= '0;
            wdata_q <= FAN_ON_VAL;
            fan_q   <= 1'b1;
            fault_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
            wdata_q <= wdata_d;
            fan_q   <= fan_d;
            fault_q <= fault_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // An all-ones code means the sensor is dead: fail safe to fan on.
    always_comb begin
        if (force_on || temp_q == 32'hFFFFFFFF) nxt = 1'b1;
        else if (temp_q >= TEMP_HI)             nxt = 1'b1;
        else if (temp_q <= TEMP_LO)             nxt = 1'b0;
        else                                    nxt = fan_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        wdata_d = wdata_q;
        fan_d   = fan_q;
        fault_d = fault_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    cnt_d   = RELOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 24'd0) cnt_d = cnt_q - 24'd1;
                if (!enable)                           state_d = S_IDLE;
                else if (cnt_q == 24'd0 || poll_now)   state_d = S_RD_ADDR;
            end
            S_RD_ADDR: state_d = S_RD_CAP;
            S_RD_CAP: begin
                temp_d  = avm_readdata;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                fault_d = (temp_q == 32'hFFFFFFFF);
                if (nxt != fan_q) begin
                    wdata_d = nxt ? FAN_ON_VAL : FAN_OFF_VAL;
                    state_d = S_WR;
                end else if (enable) begin
                    cnt_d   = RELOAD;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                // WR is only reached when the decision differs, so the new state is the inverse.
                fan_d  = ~fan_q;
                wcnt_d = wcnt_q + 16'd1;
                if (enable) begin
                    cnt_d   = RELOAD;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        busy           = 1'b0;
        case (state_q)
            S_RD_ADDR, S_RD_CAP: begin
                avm_chipselect = 1'b1;
                busy           = 1'b1;
            end
            S_EVAL: busy = 1'b1;
            S_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                busy           = 1'b1;
            end
            default: ;
        endcase
    end

    assign avm_address   = 2'b00;
    assign avm_writedata = wdata_q;
    assign fan_state     = fan_q;
    assign sensor_fault  = fault_q;
    assign write_count   = wcnt_q;

endmodule

// File: doc/fan_ctrl_poll_master.md
Name: fan_ctrl_poll_master

Overview:
- Avalon-MM master that drives the fan-control PIO slave, autonomously replacing software polling.
- Periodically reads the PIO data register (address 0 returns in_port, the temperature sensor code) and applies hysteresis.
- Writes the fan on/off value back to the same register (address 0 drives out_port) only when the decision changes.
- Sits in the pcihellocore system between the fan_ctrl PIO s1 port and a small status/control register block.

Parameters:
- POLL_CYCLES, 50000, clocks between polls; legal range 2..2^24-1.
- TEMP_HI, 32'd70, unsigned threshold; sensor code at or above this turns the fan on.
- TEMP_LO, 32'd60, unsigned threshold; sensor code at or below this turns the fan off. Must be < TEMP_HI.
- FAN_ON_VAL, 32'h00000001, writedata for fan on (matches the slave's reset value).
- FAN_OFF_VAL, 32'h00000000, writedata for fan off.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = polling active
- poll_now  in  1  single-cycle pulse; skips the remaining wait
- force_on  in  1  level; overrides the decision to on
- avm_address  out  2  Avalon-MM address; always 0
- avm_chipselect  out  1  Avalon-MM chipselect
- avm_write_n  out  1  Avalon-MM write strobe, active-low
- avm_writedata  out  32  Avalon-MM write data
- avm_readdata  in  32  slave readdata; registered in the slave, fixed read latency 1
- fan_state  out  1  current commanded fan state (1 = on)
- sensor_fault  out  1  last read returned 32'hFFFFFFFF
- busy  out  1  FSM is outside IDLE and WAIT
- write_count  out  16  number of writes issued; wraps

Behaviour:
- Reset (asynchronous, immediate) sets: state IDLE, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=FAN_ON_VAL, fan_state=1 (mirrors the slave's reset value), sensor_fault=0, busy=0, write_count=0, wait counter=0.
- All other logic is synchronous to the rising edge of clk.
- IDLE:
  - If enable=1, load the counter with POLL_CYCLES-1 and go to WAIT.
- WAIT:
  - Counter decrements by 1 each cycle.
  - Go to RD_ADDR when the counter is 0 or poll_now=1.
  - If enable=0, go to IDLE.
  - If enable=0 and poll_now=1 in the same cycle, enable wins.
- RD_ADDR (1 cycle): avm_chipselect=1, avm_write_n=1, avm_address=0. Go to RD_CAP.
- RD_CAP (1 cycle): same bus outputs as RD_ADDR. Capture avm_readdata into temp_q at the closing edge. Go to EVAL.
- EVAL (1 cycle): bus idle (chipselect=0). Compute next fan value (nxt):
  - force_on=1 or temp_q==32'hFFFFFFFF: nxt=1.
  - Else temp_q>=TEMP_HI: nxt=1.
  - Else temp_q<=TEMP_LO: nxt=0.
  - Else nxt=fan_state (hold).
  - All compares are 32-bit unsigned.
  - sensor_fault <= (temp_q==32'hFFFFFFFF). It is updated on every EVAL, so it clears on the next valid read.
  - If nxt != fan_state, go to WR. Otherwise reload the counter and go to WAIT, or go to IDLE if enable=0.
- WR (1 cycle): avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata = nxt ? FAN_ON_VAL : FAN_OFF_VAL.
  - fan_state <= nxt.
  - write_count <= write_count+1, wrapping 16'hFFFF to 0.
  - Then reload the counter and go to WAIT, or go to IDLE if enable=0.
- Deasserting enable during RD_ADDR, RD_CAP, EVAL or WR never aborts the transaction. The current sequence completes, then the FSM goes to IDLE.
- poll_now outside WAIT is ignored (not queued).
- Outside RD_ADDR/RD_CAP/WR: avm_chipselect=0 and avm_write_n=1. avm_writedata holds its last value.
- busy=1 in RD_ADDR, RD_CAP, EVAL and WR.
- Latency:
  - Counter expiry to first read cycle: 1 clock.
  - poll_now to write asserted: 4 clocks (WAIT→RD_ADDR→RD_CAP→EVAL→WR).
  - Poll period: POLL_CYCLES + 3 clocks without a write, +4 with one.
- Reset asserted mid-WR: write_n returns to 1 immediately and fan_state returns to 1. This is consistent with the slave also resetting to on.

Test Plan:
- Reset then enable=1, POLL_CYCLES=4, readdata=50: the first read cycle (chipselect=1, write_n=1, address=0) starts 4 clocks after WAIT entry. EVAL sets fan_state=0. WR drives writedata=0, write_count=1.
- Hysteresis with fan off: readdata=65 gives no write. readdata=70 gives a write of 1. Then readdata=61 gives no write, and readdata=60 gives a write of 0. write_count ends at 3.
- readdata=32'hFFFFFFFF while fan off: sensor_fault=1 and a write of 1 is issued. The next read of 40 gives sensor_fault=0 and a write of 0.
- force_on=1 with readdata=10 and fan on: no write, fan_state stays 1. Release force_on: the next poll writes 0.
- poll_now pulse 2 cycles into a 50000-cycle WAIT with readdata=80 and fan off: chipselect rises on the next clock and WR occurs 4 clocks after the pulse. Drop enable during RD_CAP: WR still occurs, then the FSM goes to IDLE with chipselect held 0.
- Assert reset during WR: write_n=1, chipselect=0, fan_state=1 and write_count=0 within the same cycle, with no clock edge required.
